// File: rtl/ftsd_scan_if.sv
// ftsd_scan_if: frame input handshake and scan output bundle for ftsd_scan_ctl.
//   in_bcd[15:0]   new 4-digit BCD frame, [15:12] = leftmost digit
//   in_valid       in_bcd valid
//   in_ready       scheduler can accept a frame (pending buffer empty)
//   lz_blank_en    1 = blank leading zeros
//   bcd[3:0]       digit value to the segment decoder
//   ftsd_ctl[3:0]  active-low digit enables, bit i = digit i
//   frame_done     1-cycle pulse at the start of each new frame
// master = frame producer / display consumer, slave = scan controller.
interface ftsd_scan_if;
    logic [15:0] in_bcd;
    logic        in_valid;
    logic        in_ready;
    logic        lz_blank_en;
    logic [3:0]  bcd;
    logic [3:0]  ftsd_ctl;
    logic        frame_done;

    modport master (
        output in_bcd, in_valid, lz_blank_en,
        input  in_ready, bcd, ftsd_ctl, frame_done
    );

    modport slave (
        input  in_bcd, in_valid, lz_blank_en,
        output in_ready, bcd, ftsd_ctl, frame_done
    );
endinterface

// File: rtl/ftsd_scan_ctl.sv
// ftsd_scan_ctl: time-multiplexed scan scheduler for a 4-digit seven-segment display.
// Each digit gets a slot of SCAN_DIV cycles: BLANK_CYC cycles with all enables off (anti-ghosting)
// followed by the show phase. New frames arrive via valid/ready into a one-entry pending buffer and
// are swapped into the display register only at the frame boundary, so a frame never tears.
// Ports:
//   clk   system clock
//   rst   synchronous reset, active-high
//   bus   ftsd_scan_if.slave (in_bcd/in_valid/in_ready, lz_blank_en, bcd, ftsd_ctl, frame_done)
module ftsd_scan_ctl #(
    parameter int unsigned DIV_WIDTH = 16,
    parameter int unsigned SCAN_DIV  = 50000,
    parameter int unsigned BLANK_CYC = 16
) (
    input logic        clk,
    input logic        rst,
    ftsd_scan_if.slave bus
);

    localparam logic [DIV_WIDTH-1:0] SlotLast  = DIV_WIDTH'(SCAN_DIV - 1);
    localparam logic [DIV_WIDTH-1:0] BlankLast = DIV_WIDTH'(BLANK_CYC - 1);

    typedef enum logic [0:0] {StBlank, StShow} state_e;

    state_e               state_q, state_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [1:0]           idx_q, idx_d;
    logic [15:0]          disp_q, disp_d;
    logic [15:0]          pend_q, pend_d;
    logic                 pend_full_q, pend_full_d;
    logic [3:0]           bcd_q, bcd_d;
    logic [3:0]           ctl_q, ctl_d;
    logic                 frame_done_q, frame_done_d;

    logic slot_end;
    logic boundary;
    logic xfer;
    logic zero3, zero2, zero1;
    logic blank_digit;

    // No path from in_valid: ready depends only on buffer occupancy and reset.
    assign bus.in_ready = ~pend_full_q & ~rst;
    assign xfer         = bus.in_valid & bus.in_ready;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        disp_d       = disp_q;
        pend_d       = pend_q;
        pend_full_d  = pend_full_q;
        slot_end     = (state_q == StShow) && (cnt_q == SlotLast);
        boundary     = slot_end && (idx_q == 2'd3);
        cnt_d        = slot_end ? '0 : cnt_q + 1'b1;

        unique case (state_q)
            StBlank: begin
                if (cnt_q == BlankLast) state_d = StShow;
            end
            StShow: begin
                if (slot_end) begin
                    state_d = StBlank;
                    idx_d   = idx_q + 2'd1;
                end
            end
        endcase

        // Swap and accept are mutually exclusive: in_ready is low whenever pend is full.
        if (boundary && pend_full_q) begin
            disp_d      = pend_q;
            pend_full_d = 1'b0;
        end
        if (xfer) begin
            pend_d      = bus.in_bcd;
            pend_full_d = 1'b1;
        end

        // Outputs are registered from next-state values so they line up with state_q.
        zero3       = (disp_d[15:12] == 4'h0);
        zero2       = zero3 && (disp_d[11:8] == 4'h0);
        zero1       = zero2 && (disp_d[7:4] == 4'h0);
        blank_digit = 1'b0;
        if (bus.lz_blank_en) begin
            unique case (idx_d)
                2'd3:    blank_digit = zero3;
                2'd2:    blank_digit = zero2;
                2'd1:    blank_digit = zero1;
                default: blank_digit = 1'b0;
            endcase
        end

        bcd_d        = disp_d[{idx_d, 2'b00} +: 4];
        ctl_d        = 4'b1111;
        if ((state_d == StShow) && !blank_digit) ctl_d = ~(4'b0001 << idx_d);
        frame_done_d = boundary;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StBlank;
            cnt_q        <= '0;
            idx_q        <= 2'd0;
            disp_q       <= 16'h0000;
            pend_q       <= 16'h0000;
            pend_full_q  <= 1'b0;
            bcd_q        <= 4'h0;
            ctl_q        <= 4'b1111;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            disp_q       <= disp_d;
            pend_q       <= pend_d;
            pend_full_q  <= pend_full_d;
            bcd_q        <= bcd_d;
            ctl_q        <= ctl_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.bcd        = bcd_q;
    assign bus.ftsd_ctl   = ctl_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_ftsd_scan_ctl.sv
// tb_ftsd_scan_ctl: directed scenarios followed by random traffic, every cycle compared against a
// timeline model: slot = t/8, position in slot = t%8, frame boundary after t%32 == 31.
module tb_ftsd_scan_ctl;
    logic clk = 1'b0;
    logic rst = 1'b1;

    ftsd_scan_if bus ();

    ftsd_scan_ctl #(
        .DIV_WIDTH(16),
        .SCAN_DIV (8),
        .BLANK_CYC(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          t      = 0;
    logic [15:0] m_disp = 16'h0;
    logic [15:0] m_pend = 16'h0;
    bit          m_pend_full = 1'b0;
    bit          m_lz   = 1'b0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
        end
    endtask

    function automatic logic [3:0] exp_ctl();
        int idx = (t / 8) % 4;
        if (t % 8 < 2) return 4'hF;
        if (m_lz && idx > 0 && (m_disp >> (4 * idx)) == 16'h0) return 4'hF;
        return 4'(15 - (1 << idx));
    endfunction

    function automatic logic [3:0] exp_bcd();
        int idx = (t / 8) % 4;
        return 4'((m_disp >> (4 * idx)) & 16'hF);
    endfunction

    task automatic tick();
        bit          v_s, rdy_s, rst_s, lz_s;
        logic [15:0] d_s;
        v_s   = bus.in_valid;
        rdy_s = !m_pend_full && !rst;
        rst_s = rst;
        lz_s  = bus.lz_blank_en;
        d_s   = bus.in_bcd;
        @(posedge clk);
        #1;
        if (rst_s) begin
            t           = 0;
            m_disp      = 16'h0;
            m_pend_full = 1'b0;
        end else begin
            if (t % 32 == 31 && m_pend_full) begin
                m_disp      = m_pend;
                m_pend_full = 1'b0;
            end
            if (v_s && rdy_s) begin
                m_pend      = d_s;
                m_pend_full = 1'b1;
            end
            t++;
        end
        m_lz = lz_s;
        chk("ftsd_ctl", 16'(bus.ftsd_ctl), 16'(exp_ctl()));
        chk("bcd", 16'(bus.bcd), 16'(exp_bcd()));
        chk("frame_done", 16'(bus.frame_done), 16'(t > 0 && t % 32 == 0));
        chk("in_ready", 16'(bus.in_ready), 16'(!m_pend_full && !rst));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic run_to(input int target);
        int n = 0;
        while (t != target && n < 300) begin
            tick();
            n++;
        end
        chk("run_to_reached", 16'(t), 16'(target));
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        run(n);
        rst = 1'b0;
    endtask

    task automatic send(input logic [15:0] v);
        bus.in_valid = 1'b1;
        bus.in_bcd   = v;
        tick();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        bus.in_valid    = 1'b0;
        bus.in_bcd      = 16'h0;
        bus.lz_blank_en = 1'b0;

        // Reset and idle scan of an all-zero frame.
        do_reset(3);
        run_to(32);
        chk("fd_cycle32", 16'(bus.frame_done), 16'h1);
        run(8);

        // Single frame load, shown from the next frame.
        do_reset(2);
        run_to(5);
        send(16'h1234);
        chk("ready_low_after_accept", 16'(bus.in_ready), 16'h0);
        run_to(34);
        chk("frame2_digit0", 16'(bus.bcd), 16'h4);
        chk("frame2_ctl0", 16'(bus.ftsd_ctl), 16'hE);
        run_to(58);
        chk("frame2_digit3", 16'(bus.bcd), 16'h1);

        // Back-pressure: second frame waits until the boundary frees the buffer.
        do_reset(1);
        run_to(3);
        bus.in_valid = 1'b1;
        bus.in_bcd   = 16'hABCD;
        tick();
        bus.in_bcd   = 16'h5678;
        run_to(32);
        tick();
        bus.in_valid = 1'b0;
        run_to(34);
        chk("bp_frame2", 16'(bus.bcd), 16'hD);
        run_to(66);
        chk("bp_frame3", 16'(bus.bcd), 16'h8);

        // Leading-zero blanking.
        do_reset(1);
        bus.lz_blank_en = 1'b1;
        run_to(3);
        send(16'h0050);
        run_to(42);
        chk("lz_digit1_ctl", 16'(bus.ftsd_ctl), 16'hD);
        run_to(50);
        chk("lz_digit2_ctl", 16'(bus.ftsd_ctl), 16'hF);
        send(16'h0000);
        run(40);
        bus.lz_blank_en = 1'b0;

        // Reset during digit2 show with a pending frame.
        do_reset(1);
        run_to(3);
        send(16'h4321);
        run_to(35);
        send(16'h9999);
        run_to(52);
        rst = 1'b1;
        tick();
        chk("rst_ctl", 16'(bus.ftsd_ctl), 16'hF);
        rst = 1'b0;
        run_to(34);
        chk("pend_discarded", 16'(bus.bcd), 16'h0);

        // Accept on the boundary cycle with the buffer empty.
        run_to(63);
        send(16'h7E1F);
        chk("boundary_keep", 16'(bus.bcd), 16'h0);
        run_to(98);
        chk("boundary_next", 16'(bus.bcd), 16'hF);

        // Random traffic.
        for (int i = 0; i < 1200; i++) begin
            bus.in_valid = ($urandom_range(0, 3) == 0);
            bus.in_bcd   = 16'($urandom);
            if ($urandom_range(0, 49) == 0) bus.lz_blank_en = ~bus.lz_blank_en;
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0;
        bus.in_valid = 1'b0;
        run(40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
